// File: rtl/gen192_pkg.sv
// Shared definitions for the 192-bit TX bench generators: word layout,
// scheduler state encoding and the 16-bit LFSR tap set.
package gen192_pkg;

    localparam int WORD_W = 192;

    // Probe word layout: low 32 bits carry the cycle timestamp, the next
    // nibble is zero padding, and the rest is passed through from seq_data.
    localparam int TIME_LSB = 0;
    localparam int TIME_W   = 32;
    localparam int PAD_LSB  = 32;
    localparam int PAD_W    = 4;
    localparam int HDR_LSB  = PAD_LSB + PAD_W;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_FULL = 2'b01,
        ST_RUN_LOW  = 2'b10
    } sched_state_t;

    // Feedback bit shifted into the LSB on every LFSR advance.
    function automatic logic lfsr_feedback(input logic [15:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/gen192_lfsr16.sv
// 16-bit Fibonacci LFSR with a reset seed and an advance enable.
module gen192_lfsr16
    import gen192_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] value
);

    // Shift left, feeding the tap parity into bit 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[14:0], lfsr_feedback(value)};
        end
    end

endmodule

// File: rtl/gen192_tx_sched.sv
// Shares the 192-bit TX word interface between the sequence source and an
// internal timestamp-probe source, alternating full-rate and low-rate phases
// with LFSR throttling. All transfer decisions are same-cycle combinational.
module gen192_tx_sched
    import gen192_pkg::*;
#(
    parameter int unsigned PHASE_LEN      = 40000,
    parameter int unsigned PROBE_INTERVAL = 1024,
    parameter int unsigned FULL_THR       = 1020,
    parameter int unsigned LOW_THR        = 102,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              ideal,
    input  logic              seq_req,
    input  logic [WORD_W-1:0] seq_data,
    output logic              seq_grant,
    output logic              out_txen,
    output logic [WORD_W-1:0] data,
    output logic              probe_sent,
    output logic [1:0]        state,
    output logic [31:0]       tx_count,
    output logic [15:0]       probe_count
);

    localparam logic [31:0] PHASE_LAST = 32'(PHASE_LEN - 1);
    localparam logic        PROBE_EN   = (PROBE_INTERVAL != 0);
    localparam logic [31:0] PROBE_LAST = PROBE_EN ? 32'(PROBE_INTERVAL - 1) : 32'd0;
    // 11-bit thresholds so that 1024 means "always pass".
    localparam logic [10:0] FULL_THR_C = 11'(FULL_THR);
    localparam logic [10:0] LOW_THR_C  = 11'(LOW_THR);

    sched_state_t cur_state;
    sched_state_t next_state;

    logic [15:0] lfsr_val;
    logic        lfsr_unused;
    logic [31:0] time_cnt;
    logic [31:0] phase_cnt;
    logic [31:0] interval_cnt;
    logic        probe_pending;

    logic        run;
    logic [10:0] thr;
    logic        throttle_ok;
    logic        probe_trigger;
    logic        phase_hit;
    logic        start_run;
    logic        stop_run;
    logic        phase_wrap;

    // Throttle source; free-running outside reset.
    gen192_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .value   (lfsr_val)
    );

    // Only the low ten LFSR bits feed the throttle compare.
    assign lfsr_unused = ^lfsr_val[15:10];

    assign state = cur_state;

    // Transfer arbitration: a pending probe wins and ignores the throttle.
    always_comb begin
        run           = (cur_state != ST_IDLE);
        thr           = (cur_state == ST_RUN_LOW) ? LOW_THR_C : FULL_THR_C;
        throttle_ok   = ({1'b0, lfsr_val[9:0]} < thr);
        probe_sent    = run & ideal & probe_pending;
        seq_grant     = run & ideal & ~probe_pending & seq_req & throttle_ok;
        out_txen      = probe_sent | seq_grant;
        probe_trigger = PROBE_EN & seq_grant & (interval_cnt >= PROBE_LAST);
        phase_hit     = out_txen & (phase_cnt == PHASE_LAST);
    end

    // Output word: timestamped probe, pass-through sequence word, or zero.
    always_comb begin
        data = '0;
        if (probe_sent) begin
            data = {seq_data[WORD_W-1:HDR_LSB], {PAD_W{1'b0}}, time_cnt};
        end else if (seq_grant) begin
            data = seq_data;
        end
    end

    // Phase state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-phase decode; stop outranks both start and a phase switch.
    always_comb begin
        next_state = cur_state;
        start_run  = 1'b0;
        stop_run   = 1'b0;
        phase_wrap = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_state = ST_RUN_FULL;
                    start_run  = 1'b1;
                end
            end
            ST_RUN_FULL: begin
                if (stop) begin
                    next_state = ST_IDLE;
                    stop_run   = 1'b1;
                end else if (phase_hit) begin
                    next_state = ST_RUN_LOW;
                    phase_wrap = 1'b1;
                end
            end
            ST_RUN_LOW: begin
                if (stop) begin
                    next_state = ST_IDLE;
                    stop_run   = 1'b1;
                end else if (phase_hit) begin
                    next_state = ST_RUN_FULL;
                    phase_wrap = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Cycle timestamp, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            time_cnt <= '0;
        end else begin
            time_cnt <= time_cnt + 32'd1;
        end
    end

    // Transfer counters and the per-phase word count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_count    <= '0;
            probe_count <= '0;
            phase_cnt   <= '0;
        end else begin
            if (out_txen) begin
                tx_count <= tx_count + 32'd1;
            end
            if (probe_sent) begin
                probe_count <= probe_count + 16'd1;
            end
            if (start_run || phase_wrap) begin
                phase_cnt <= '0;
            end else if (out_txen) begin
                phase_cnt <= phase_cnt + 32'd1;
            end
        end
    end

    // Probe scheduling: the interval counter counts every transfer and arms a
    // probe when a sequence word lands on the last slot of the interval.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interval_cnt  <= '0;
            probe_pending <= 1'b0;
        end else begin
            if (start_run || probe_trigger) begin
                interval_cnt <= '0;
            end else if (out_txen) begin
                interval_cnt <= interval_cnt + 32'd1;
            end
            if (start_run || stop_run) begin
                probe_pending <= 1'b0;
            end else if (probe_trigger) begin
                probe_pending <= 1'b1;
            end else if (probe_sent) begin
                probe_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen192_tx_sched.sv
// Bench for gen192_tx_sched: directed phases plus randomized traffic, every
// cycle compared against a behavioural model of the scheduling rules.
module tb_gen192_tx_sched;

    localparam int          PH   = 8;
    localparam int          PI   = 4;
    localparam int          FT   = 1024;
    localparam int          LT   = 102;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         ideal = 1'b0;
    logic         seq_req = 1'b0;
    logic [191:0] seq_data = '0;
    logic         seq_grant;
    logic         out_txen;
    logic [191:0] data;
    logic         probe_sent;
    logic [1:0]   state;
    logic [31:0]  tx_count;
    logic [15:0]  probe_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int           m_state;
    logic [31:0]  m_tx, m_phase, m_interval, m_time;
    logic [15:0]  m_probe, m_lfsr;
    bit           m_pending;
    bit           e_txen, e_grant, e_probe;
    logic [191:0] e_data;

    // Values sampled mid-cycle by the last step
    logic         s_txen, s_probe;
    logic [191:0] s_data;

    bit measure = 1'b0;
    int low_elig = 0;
    int low_grant = 0;

    gen192_tx_sched #(
        .PHASE_LEN      (PH),
        .PROBE_INTERVAL (PI),
        .FULL_THR       (FT),
        .LOW_THR        (LT),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .ideal       (ideal),
        .seq_req     (seq_req),
        .seq_data    (seq_data),
        .seq_grant   (seq_grant),
        .out_txen    (out_txen),
        .data        (data),
        .probe_sent  (probe_sent),
        .state       (state),
        .tx_count    (tx_count),
        .probe_count (probe_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_tx       = '0;
        m_phase    = '0;
        m_interval = '0;
        m_time     = '0;
        m_probe    = '0;
        m_lfsr     = SEED;
        m_pending  = 1'b0;
    endtask

    function automatic logic [191:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        int thr;
        bit run;
        bit ok;
        #4;
        run     = (m_state != 0);
        thr     = (m_state == 2) ? LT : FT;
        ok      = (int'(m_lfsr[9:0]) < thr);
        e_probe = run && ideal && m_pending;
        e_grant = run && ideal && !m_pending && seq_req && ok;
        e_txen  = e_probe || e_grant;
        e_data  = '0;
        if (e_probe)      e_data = {seq_data[191:36], 4'h0, m_time};
        else if (e_grant) e_data = seq_data;

        s_txen  = out_txen;
        s_probe = probe_sent;
        s_data  = data;
        chk("out_txen", out_txen, e_txen);
        chk("seq_grant", seq_grant, e_grant);
        chk("probe_sent", probe_sent, e_probe);
        chk("data", data, e_data);
        chk("state", state, m_state[1:0]);
        chk("tx_count", tx_count, m_tx);
        chk("probe_count", probe_count, m_probe);

        if (measure && m_state == 2 && ideal && seq_req && !m_pending) begin
            low_elig++;
            if (e_grant) low_grant++;
        end

        if (!reset_n) begin
            model_reset();
        end else begin
            m_time = m_time + 1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (e_txen) begin
                m_tx       = m_tx + 1;
                m_phase    = m_phase + 1;
                m_interval = m_interval + 1;
            end
            if (e_probe) begin
                m_pending = 1'b0;
                m_probe   = m_probe + 1;
            end
            // interval already includes this word, so PI here means "was PI-1"
            if (e_grant && PI != 0 && m_interval >= PI) begin
                m_pending  = 1'b1;
                m_interval = '0;
            end
            if (m_state == 0) begin
                if (start && !stop) begin
                    m_state    = 1;
                    m_phase    = '0;
                    m_interval = '0;
                    m_pending  = 1'b0;
                end
            end else if (stop) begin
                m_state   = 0;
                m_pending = 1'b0;
            end else if (e_txen && m_phase == PH) begin
                m_state = 3 - m_state;
                m_phase = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        logic [31:0] tx_snap;
        logic [15:0] pc_snap;

        model_reset();
        @(posedge clk);
        #1;
        repeat (3) step();
        chk("rst_tx_count", tx_count, 32'd0);
        chk("rst_state", state, 2'b00);
        chk("rst_txen", s_txen, 1'b0);

        // Start with continuous traffic; full phase passes every word.
        reset_n = 1'b1;
        ideal   = 1'b1;
        seq_req = 1'b1;
        seq_data = rand_word();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_state", state, 2'b01);
        for (int k = 1; k <= 8; k++) begin
            seq_data = rand_word();
            step();
            chk("full_txen", s_txen, 1'b1);
            if (k == 5) begin
                chk("probe5_sent", s_probe, 1'b1);
                chk("probe5_pad", s_data[35:32], 4'h0);
                chk("probe5_hdr", s_data[191:36], seq_data[191:36]);
            end else begin
                chk("seq_sent", s_data, seq_data);
            end
        end
        chk("phase_low", state, 2'b10);

        t = 0;
        while (tx_count != 32'd10 && t < 2000) begin
            seq_data = rand_word();
            step();
            t++;
        end
        chk("tx10_reached", (t < 2000), 1'b1);
        chk("probe_cnt10", probe_count, 16'd2);

        t = 0;
        while (state != 2'b01 && t < 4000) begin
            seq_data = rand_word();
            step();
            t++;
        end
        chk("phase_full_reached", (t < 4000), 1'b1);
        chk("phase_full_tx", tx_count, 32'd16);

        // Randomized traffic with occasional start/stop/reset.
        for (int i = 0; i < 12000; i++) begin
            ideal    = ($urandom_range(7) != 0);
            seq_req  = ($urandom_range(3) != 0);
            seq_data = rand_word();
            start    = ($urandom_range(63) == 0);
            stop     = ($urandom_range(399) == 0);
            reset_n  = ($urandom_range(2999) != 0);
            step();
        end
        start = 1'b0;
        stop = 1'b0;
        reset_n = 1'b1;

        // Long continuous run, measuring the low-phase grant rate.
        ideal = 1'b1;
        seq_req = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        measure = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            seq_data = rand_word();
            step();
        end
        measure = 1'b0;
        chk("low_elig_min", (low_elig > 2000), 1'b1);
        chk("low_rate", (low_grant * 10240 >= low_elig * 816) &&
                        (low_grant * 10240 <= low_elig * 1224), 1'b1);

        // Stall with a probe pending: nothing moves, probe leaves first.
        t = 0;
        while (!m_pending && t < 2000) begin
            seq_data = rand_word();
            step();
            t++;
        end
        chk("pending_reached", (t < 2000), 1'b1);
        tx_snap = tx_count;
        pc_snap = probe_count;
        ideal = 1'b0;
        repeat (50) begin
            seq_data = rand_word();
            step();
        end
        chk("stall_tx", tx_count, tx_snap);
        chk("stall_probe_cnt", probe_count, pc_snap);
        ideal = 1'b1;
        seq_data = rand_word();
        step();
        chk("stall_probe_out", s_probe, 1'b1);
        chk("stall_probe_cnt_after", probe_count, pc_snap + 16'd1);

        // Stop coinciding with a transfer in the full phase.
        t = 0;
        while (state != 2'b01 && t < 2000) begin
            seq_data = rand_word();
            step();
            t++;
        end
        chk("full_for_stop", (t < 2000), 1'b1);
        tx_snap = tx_count;
        stop = 1'b1;
        seq_data = rand_word();
        step();
        stop = 1'b0;
        chk("stop_txen", s_txen, 1'b1);
        chk("stop_counted", tx_count, tx_snap + 32'd1);
        chk("stop_idle", state, 2'b00);
        repeat (3) step();
        chk("idle_txen", s_txen, 1'b0);

        // Reset in the middle of a run.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        step();
        chk("mid_rst_txen", out_txen, 1'b0);
        chk("mid_rst_data", data, 192'd0);
        chk("mid_rst_state", state, 2'b00);
        chk("mid_rst_tx", tx_count, 32'd0);
        chk("mid_rst_probe", probe_count, 16'd0);
        reset_n = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
